// File: rtl/backend_pkg.sv
// Shared definitions for the singles backend: arbiter state encoding,
// counter width and index-width helper.
package backend_pkg;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } arb_state_e;

  localparam int unsigned CNT_WIDTH = 32;

  // Width of an index into n items; never narrower than one bit.
  function automatic int unsigned idx_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/singles_arbiter_rr_pick.sv
// Combinational round-robin selector: first set request after 'last',
// wrapping modulo N.
module rr_pick
  import backend_pkg::*;
#(
  parameter int unsigned N = 4
) (
  input  logic [N-1:0]          req,
  input  logic [idx_w(N)-1:0]   last,
  output logic                  found,
  output logic [idx_w(N)-1:0]   idx
);

  localparam int unsigned IW = idx_w(N);

  logic [IW-1:0] cand;

  // Scan last+1, last+2, ... last+N and keep the first requester.
  always_comb begin
    found = 1'b0;
    idx   = '0;
    cand  = '0;
    for (int unsigned i = 1; i <= N; i++) begin
      cand = IW'((32'(last) + i) % N);
      if (!found && req[cand]) begin
        found = 1'b1;
        idx   = cand;
      end
    end
  end

endmodule

// File: rtl/singles_arbiter.sv
// Round-robin merge of NMODULES frontend singles streams into one
// registered output towards the ethernet tx fifo, with bounded bursts
// and per-stream saturating word counters.
module singles_arbiter
  import backend_pkg::*;
#(
  parameter int unsigned NMODULES  = 4,
  parameter int unsigned LENGTH    = 128,
  parameter int unsigned BURST_MAX = 16
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NMODULES-1:0]           en_mask,
  input  logic [NMODULES-1:0]           in_valid,
  output logic [NMODULES-1:0]           in_ready,
  input  logic [LENGTH*NMODULES-1:0]    in_data,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [LENGTH-1:0]             out_data,
  output logic [idx_w(NMODULES)-1:0]    out_src,
  input  logic                          cnt_clear,
  input  logic [idx_w(NMODULES)-1:0]    cnt_sel,
  output logic [CNT_WIDTH-1:0]          cnt_value,
  output logic                          busy
);

  localparam int unsigned IW = idx_w(NMODULES);
  localparam int unsigned BW = $clog2(BURST_MAX + 1);

  arb_state_e                          state;
  logic [IW-1:0]                       grant;
  logic [IW-1:0]                       last_grant;
  logic [BW-1:0]                       burst_cnt;
  logic [NMODULES-1:0][CNT_WIDTH-1:0]  cnt_q;
  logic [NMODULES-1:0][CNT_WIDTH-1:0]  cnt_d;

  logic [NMODULES-1:0]  elig_c;
  logic                 pick_found_c;
  logic [IW-1:0]        pick_idx_c;
  logic                 grant_ok_c;
  logic [LENGTH-1:0]    grant_data_c;
  logic                 accept_c;
  logic                 xfer_c;
  logic                 burst_last_c;
  logic [CNT_WIDTH-1:0] sel_cnt_c;

  assign elig_c = in_valid & en_mask;

  rr_pick #(
    .N (NMODULES)
  ) u_rr_pick (
    .req   (elig_c),
    .last  (last_grant),
    .found (pick_found_c),
    .idx   (pick_idx_c)
  );

  // Eligibility and payload of the currently granted stream.
  always_comb begin
    grant_ok_c   = 1'b0;
    grant_data_c = '0;
    for (int unsigned k = 0; k < NMODULES; k++) begin
      if (grant == IW'(k)) begin
        grant_ok_c   = elig_c[k];
        grant_data_c = in_data[k*LENGTH +: LENGTH];
      end
    end
  end

  // Output register can take a word when empty or draining this cycle.
  assign accept_c     = ~out_valid | out_ready;
  assign xfer_c       = rst_n && (state == ST_GRANT) && grant_ok_c && accept_c;
  assign burst_last_c = (burst_cnt == BW'(BURST_MAX - 1));

  // Pop strobe back to the granted stream fifo only.
  always_comb begin
    in_ready = '0;
    for (int unsigned k = 0; k < NMODULES; k++) begin
      in_ready[k] = xfer_c && (grant == IW'(k));
    end
  end

  // Arbitration FSM: pick in IDLE, stream a bounded burst in GRANT.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      busy       <= 1'b0;
      grant      <= '0;
      last_grant <= IW'(NMODULES - 1);
      burst_cnt  <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (pick_found_c) begin
            state     <= ST_GRANT;
            busy      <= 1'b1;
            grant     <= pick_idx_c;
            burst_cnt <= '0;
          end
        end
        ST_GRANT: begin
          if (xfer_c) begin
            burst_cnt <= burst_cnt + BW'(1);
          end
          // Backpressure alone holds the grant; source loss or a full burst releases it.
          if (!grant_ok_c || (xfer_c && burst_last_c)) begin
            state      <= ST_IDLE;
            busy       <= 1'b0;
            last_grant <= grant;
          end
        end
        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  // Output word register; holds while stalled, empties when drained.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_src   <= '0;
    end else if (xfer_c) begin
      out_valid <= 1'b1;
      out_data  <= grant_data_c;
      out_src   <= grant;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

  // Next counter values: clear wins, otherwise saturating increment.
  always_comb begin
    cnt_d = cnt_q;
    if (cnt_clear) begin
      cnt_d = '0;
    end else begin
      for (int unsigned k = 0; k < NMODULES; k++) begin
        if (xfer_c && (grant == IW'(k)) && (cnt_q[k] != '1)) begin
          cnt_d[k] = cnt_q[k] + CNT_WIDTH'(1);
        end
      end
    end
  end

  // Counter readback mux.
  always_comb begin
    sel_cnt_c = '0;
    for (int unsigned k = 0; k < NMODULES; k++) begin
      if (cnt_sel == IW'(k)) begin
        sel_cnt_c = cnt_q[k];
      end
    end
  end

  // Counter storage and registered readback.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q     <= '0;
      cnt_value <= '0;
    end else begin
      cnt_q     <= cnt_d;
      cnt_value <= sel_cnt_c;
    end
  end

endmodule

// File: tb/tb_singles_arbiter.sv
// Directed bench for singles_arbiter: fifo models per stream, an
// in-order scoreboard on the output, a vector table and corner sequences.
module tb_singles_arbiter;

  localparam int N = 4;
  localparam int L = 128;

  typedef struct packed {
    logic [1:0]   src;
    logic [127:0] data;
  } exp_t;

  typedef struct packed {
    logic [3:0][7:0]  nwords;
    logic [3:0]       en;
    logic [1:0]       first;
    logic [3:0][31:0] cnt;
    logic [7:0]       total;
  } vec_t;

  logic           clk;
  logic           rst_n;
  logic [N-1:0]   en_mask;
  logic [N-1:0]   in_valid;
  logic [N-1:0]   in_ready;
  logic [L*N-1:0] in_data;
  logic           out_valid;
  logic           out_ready;
  logic [L-1:0]   out_data;
  logic [1:0]     out_src;
  logic           cnt_clear;
  logic [1:0]     cnt_sel;
  logic [31:0]    cnt_value;
  logic           busy;

  singles_arbiter #(
    .NMODULES  (4),
    .LENGTH    (128),
    .BURST_MAX (16)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .en_mask   (en_mask),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_src   (out_src),
    .cnt_clear (cnt_clear),
    .cnt_sel   (cnt_sel),
    .cnt_value (cnt_value),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          n_chk;
  int          n_fail;
  int          cyc;
  int unsigned seq;
  logic        rst_q;
  logic [3:0]  en_q;
  logic        clr_q;
  logic [1:0]  sel_q;

  logic [127:0] fifo [4][$];
  exp_t         exp_q [$];
  logic [1:0]   log_src [$];
  int           log_cyc [$];
  vec_t         vecs [4];

  task automatic chk(input string name, input logic [135:0] act, input logic [135:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  task automatic fail_now(input string name);
    n_chk++;
    n_fail++;
    $display("FAIL %s", name);
  endtask

  // One clock: drive at negedge, score the output, then pop accepted words.
  task automatic cycle(input logic rdy);
    exp_t e;
    @(negedge clk);
    rst_n     = rst_q;
    en_mask   = en_q;
    cnt_clear = clr_q;
    cnt_sel   = sel_q;
    out_ready = rdy;
    if (out_valid && rdy) begin
      if (exp_q.size() == 0) begin
        fail_now("unexpected_out_word");
      end else begin
        e = exp_q.pop_front();
        chk("out_word", {out_src, out_data}, {e.src, e.data});
      end
      log_src.push_back(out_src);
      log_cyc.push_back(cyc);
    end
    for (int k = 0; k < N; k++) begin
      in_valid[k] = (fifo[k].size() != 0);
      in_data[k*L +: L] = (fifo[k].size() != 0) ? fifo[k][0] : '0;
    end
    #1;
    for (int k = 0; k < N; k++) begin
      if (in_ready[k]) begin
        if (fifo[k].size() == 0) begin
          fail_now($sformatf("ready_without_valid_%0d", k));
        end else begin
          e.src  = 2'(k);
          e.data = fifo[k].pop_front();
          exp_q.push_back(e);
        end
      end
    end
    cyc++;
  endtask

  task automatic push(input int k, input int n);
    for (int i = 0; i < n; i++) begin
      fifo[k].push_back({8'(k), 24'hC0FFEE, 32'(seq), $urandom, $urandom});
      seq++;
    end
  endtask

  task automatic do_reset();
    rst_q = 1'b0;
    en_q  = 4'hF;
    clr_q = 1'b0;
    sel_q = 2'd0;
    cycle(1'b0);
    rst_q = 1'b1;
    for (int k = 0; k < N; k++) fifo[k].delete();
    exp_q.delete();
    log_src.delete();
    log_cyc.delete();
  endtask

  task automatic read_cnt(input int k, output logic [31:0] v);
    sel_q = 2'(k);
    cycle(1'b1);
    cycle(1'b1);
    v = cnt_value;
  endtask

  logic [31:0]  v;
  logic [127:0] snap;
  logic [1:0]   ord [5];
  int           n3;

  initial begin
    rst_n = 1'b0; en_mask = '0; in_valid = '0; in_data = '0;
    out_ready = 1'b0; cnt_clear = 1'b0; cnt_sel = '0;
    n_chk = 0; n_fail = 0; cyc = 0; seq = 0;
    rst_q = 1'b0; en_q = 4'hF; clr_q = 1'b0; sel_q = 2'd0;

    vecs[0] = '{nwords: {8'd0, 8'd5, 8'd0, 8'd0}, en: 4'hF, first: 2'd2,
                cnt: {32'd0, 32'd5, 32'd0, 32'd0}, total: 8'd5};
    vecs[1] = '{nwords: {8'd1, 8'd0, 8'd2, 8'd3}, en: 4'hF, first: 2'd0,
                cnt: {32'd1, 32'd0, 32'd2, 32'd3}, total: 8'd6};
    vecs[2] = '{nwords: {8'd1, 8'd0, 8'd2, 8'd3}, en: 4'b1010, first: 2'd1,
                cnt: {32'd1, 32'd0, 32'd2, 32'd0}, total: 8'd3};
    vecs[3] = '{nwords: {8'd0, 8'd0, 8'd0, 8'd20}, en: 4'hF, first: 2'd0,
                cnt: {32'd0, 32'd0, 32'd0, 32'd20}, total: 8'd20};

    // Reset values
    do_reset();
    cycle(1'b0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_src", out_src, 0);
    chk("rst_cnt_value", cnt_value, 0);
    chk("rst_in_ready", in_ready, 0);

    // Vector table: word loads per stream, enables, expected first source and counts
    for (int t = 0; t < 4; t++) begin
      do_reset();
      en_q = vecs[t].en;
      for (int k = 0; k < N; k++) push(k, int'(vecs[t].nwords[k]));
      repeat (60) cycle(1'b1);
      chk($sformatf("tbl%0d_drained", t), exp_q.size(), 0);
      chk($sformatf("tbl%0d_total", t), log_src.size(), vecs[t].total);
      if (log_src.size() == 0) fail_now($sformatf("tbl%0d_no_output", t));
      else chk($sformatf("tbl%0d_first_src", t), log_src[0], vecs[t].first);
      for (int k = 0; k < N; k++) begin
        read_cnt(k, v);
        chk($sformatf("tbl%0d_cnt%0d", t, k), v, vecs[t].cnt[k]);
      end
    end

    // All streams saturated: bursts of 16 in order 0,1,2,3,0 with one idle cycle between
    do_reset();
    ord[0] = 2'd0; ord[1] = 2'd1; ord[2] = 2'd2; ord[3] = 2'd3; ord[4] = 2'd0;
    for (int k = 0; k < N; k++) push(k, 40);
    repeat (95) cycle(1'b1);
    if (log_src.size() < 80) begin
      fail_now("rr_too_few_words");
    end else begin
      for (int i = 0; i < 80; i++) begin
        chk($sformatf("rr_src_%0d", i), log_src[i], ord[i/16]);
        if (i > 0) chk($sformatf("rr_gap_%0d", i), log_cyc[i] - log_cyc[i-1], (i % 16 == 0) ? 2 : 1);
      end
    end

    // Backpressure on stream 1 for 10 cycles
    do_reset();
    push(1, 30);
    repeat (5) cycle(1'b1);
    cycle(1'b0);
    snap = out_data;
    chk("bp_valid", out_valid, 1);
    chk("bp_ready1_first", in_ready[1], 0);
    repeat (9) begin
      cycle(1'b0);
      chk("bp_frozen", out_data, snap);
      chk("bp_ready1", in_ready[1], 0);
    end
    repeat (60) cycle(1'b1);
    chk("bp_drained", exp_q.size(), 0);
    chk("bp_total", log_src.size(), 30);
    chk("bp_fifo_empty", fifo[1].size(), 0);

    // Stream 3 disabled mid-burst, stream 0 waiting
    do_reset();
    push(3, 10);
    repeat (4) cycle(1'b1);
    push(0, 5);
    en_q = 4'b0111;
    cycle(1'b1);
    chk("dis_ready3", in_ready[3], 0);
    chk("dis_busy_hold", busy, 1);
    cycle(1'b1);
    chk("dis_idle", busy, 0);
    repeat (20) cycle(1'b1);
    n3 = 0;
    while (n3 < log_src.size() && log_src[n3] == 2'd3) n3++;
    chk("dis_n3", n3, 3);
    if (log_src.size() <= n3) fail_now("dis_no_regrant");
    else chk("dis_next_src", log_src[n3], 0);
    chk("dis_total", log_src.size(), 8);
    chk("dis_drained", exp_q.size(), 0);

    // Counter clear versus increment, and saturation
    do_reset();
    push(0, 7);
    repeat (20) cycle(1'b1);
    read_cnt(0, v);
    chk("cnt7", v, 7);
    push(0, 1);
    cycle(1'b1);
    clr_q = 1'b1;
    cycle(1'b1);
    chk("clr_xfer", in_ready[0], 1);
    clr_q = 1'b0;
    read_cnt(0, v);
    chk("clr_wins", v, 0);
    force dut.cnt_q = {4{32'hFFFF_FFFF}};
    cycle(1'b1);
    release dut.cnt_q;
    push(0, 1);
    repeat (5) cycle(1'b1);
    read_cnt(0, v);
    chk("sat0", v, 32'hFFFF_FFFF);
    chk("sat_total", log_src.size(), 9);
    chk("sat_drained", exp_q.size(), 0);

    // Reset mid-burst with a held output word
    do_reset();
    push(1, 20);
    repeat (4) cycle(1'b1);
    cycle(1'b0);
    cycle(1'b0);
    chk("mrst_held", out_valid, 1);
    rst_q = 1'b0;
    cycle(1'b0);
    chk("mrst_ready", in_ready, 0);
    rst_q = 1'b1;
    exp_q.delete();
    log_src.delete();
    log_cyc.delete();
    push(0, 3);
    cycle(1'b1);
    chk("mrst_valid", out_valid, 0);
    chk("mrst_busy", busy, 0);
    repeat (10) cycle(1'b1);
    if (log_src.size() == 0) fail_now("mrst_no_output");
    else chk("mrst_first_src", log_src[0], 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
